// File: rtl/aes_in_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_in_dispatch_pkg
// Brief    : Shared types and defaults for the AES request dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package aes_in_dispatch_pkg;

    localparam int AES_DISP_DEPTH   = 4;
    localparam int AES_MAX_INFLIGHT = 16;

    typedef struct packed {
        logic         valid;
        logic [127:0] data;
        logic         en_de;
        logic         set_key;
    } in_packet_t;

    // Request payload as stored in the FIFO (no valid bit)
    typedef struct packed {
        logic [127:0] data;
        logic         en_de;
        logic         set_key;
    } aes_req_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } dispatch_state_t;

    function automatic in_packet_t make_packet(input aes_req_t req);
        make_packet = '{valid: 1'b1, data: req.data, en_de: req.en_de, set_key: req.set_key};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_in_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_in_dispatch_if
// Brief    : Host request valid/ready channel into the AES dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_in_dispatch_if;

    logic         host_valid;
    logic         host_ready;
    logic [127:0] host_data;
    logic         host_en_de;
    logic         host_set_key;

    modport master (
        output host_valid,
        output host_data,
        output host_en_de,
        output host_set_key,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  host_en_de,
        input  host_set_key,
        output host_ready
    );

endinterface
`default_nettype wire

// File: rtl/aes_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_fifo
// Brief    : Synchronous FIFO of AES request payloads with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_fifo
    import aes_in_dispatch_pkg::*;
#(
    parameter int DEPTH = AES_DISP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  aes_req_t               push_data,
    input  logic                   pop,
    output aes_req_t               head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    aes_req_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = push && (r_count != c_depth);
    assign w_pop  = pop && (r_count != '0);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Payload storage carries no reset; the count alone defines what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_in_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : aes_in_dispatch
// Brief    : Buffers host AES requests and issues them to the engine, holding
//            key loads until all outstanding data jobs have returned.
// Revision : 1.0 - initial release
// ============================================================================
module aes_in_dispatch
    import aes_in_dispatch_pkg::*;
#(
    parameter int DEPTH        = AES_DISP_DEPTH,
    parameter int MAX_INFLIGHT = AES_MAX_INFLIGHT
) (
    input  logic                                clk,
    input  logic                                rst,
    aes_in_dispatch_if.slave                    host,
    output in_packet_t                          data_in,
    input  logic                                load_data,
    input  logic                                eng_out_valid,
    output logic [$clog2(DEPTH):0]              fifo_count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                busy,
    output logic                                err_underflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] c_depth        = CW'(DEPTH);
    localparam logic [IW-1:0] c_max_inflight = IW'(MAX_INFLIGHT);

    dispatch_state_t r_state;
    dispatch_state_t w_state_nxt;
    logic [IW-1:0]   r_inflight;
    logic            r_err;
    aes_req_t        w_host_req;
    aes_req_t        w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_issue_ok;
    logic            w_not_empty;
    logic            w_inc;
    logic            w_dec;

    assign host.host_ready = (fifo_count < c_depth);
    assign w_push          = host.host_valid && host.host_ready;
    assign w_host_req      = '{data: host.host_data, en_de: host.host_en_de, set_key: host.host_set_key};
    assign w_not_empty     = (fifo_count != '0);
    assign w_pop           = w_issue_ok && load_data;

    aes_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_host_req),
        .pop       (w_pop),
        .head      (w_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A key at the head waits in DRAIN; it becomes issuable in the RUN cycle after inflight hits 0
    always_comb begin
        w_state_nxt = r_state;
        w_issue_ok  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_not_empty) begin
                    if (w_head.set_key) begin
                        if (r_inflight == '0) begin
                            w_issue_ok = 1'b1;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end else begin
                        w_issue_ok = (r_inflight < c_max_inflight);
                    end
                end
            end
            DRAIN: begin
                if (r_inflight == '0) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign data_in = w_issue_ok ? make_packet(w_head) : '0;

    // Key loads produce no engine output, so only data issues are counted
    assign w_inc = w_pop && !w_head.set_key;
    assign w_dec = eng_out_valid && (r_inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + IW'(1);
            end else if (!w_inc && w_dec) begin
                r_inflight <= r_inflight - IW'(1);
            end
            if (eng_out_valid && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign inflight      = r_inflight;
    assign err_underflow = r_err;
    assign busy          = (fifo_count != '0) || (r_inflight != '0);

endmodule
`default_nettype wire
